// File: rtl/mac_feeder_if.sv
// rtl/mac_feeder_if.sv - handshake, operand/result and DSP-slice signals of the MAC feeder
interface mac_feeder_if #(
  parameter int LEN_W = 8
);
  logic                    start;
  logic [LEN_W-1:0]        len;
  logic                    busy;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [17:0]      in_a;
  logic signed [17:0]      in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [47:0]      out_data;
  logic signed [17:0]      dsp_a;
  logic signed [17:0]      dsp_b;
  logic [7:0]              dsp_opmode;
  logic                    dsp_rstp;
  logic signed [47:0]      dsp_p;

  modport slave (
    input  start, len, in_valid, in_a, in_b, out_ready, dsp_p,
    output busy, in_ready, out_valid, out_data, dsp_a, dsp_b, dsp_opmode, dsp_rstp
  );

  modport master (
    output start, len, in_valid, in_a, in_b, out_ready, dsp_p,
    input  busy, in_ready, out_valid, out_data, dsp_a, dsp_b, dsp_opmode, dsp_rstp
  );
endinterface

// File: rtl/mac_feeder.sv
// rtl/mac_feeder.sv - streams operand pairs into a pipelined DSP MAC and returns the dot product
module mac_feeder #(
  parameter int LEN_W = 8,
  parameter int LAT   = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  mac_feeder_if.slave   bus
);
  localparam int DRAIN_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q;
  logic                armed_q;
  logic                busy_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                dsp_rstp_q;
  logic [LEN_W-1:0]    rem_q;
  logic [DRAIN_W-1:0]  drain_q;
  logic signed [47:0]  out_data_q;
  logic signed [17:0]  dsp_a_q;
  logic signed [17:0]  dsp_b_q;
  logic                start_d;
  logic                accept_d;

  // start is not honoured on the first edge after reset release
  assign start_d  = bus.start && armed_q;
  assign accept_d = bus.in_valid && in_ready_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dsp_rstp_q  <= 1'b1;
      rem_q       <= '0;
      drain_q     <= '0;
      out_data_q  <= '0;
      dsp_a_q     <= '0;
      dsp_b_q     <= '0;
    end else begin
      armed_q    <= 1'b1;
      dsp_rstp_q <= 1'b0;
      // bubbles feed zeros so the accumulator only ever adds zero products
      dsp_a_q    <= '0;
      dsp_b_q    <= '0;
      case (state_q)
        IDLE: begin
          if (start_d) begin
            rem_q      <= bus.len;
            dsp_rstp_q <= 1'b1;
            busy_q     <= 1'b1;
            if (bus.len == '0) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              out_data_q  <= '0;
            end else begin
              state_q    <= RUN;
              in_ready_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept_d) begin
            dsp_a_q <= bus.in_a;
            dsp_b_q <= bus.in_b;
            rem_q   <= rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
              drain_q    <= DRAIN_W'(LAT - 1);
            end
          end
        end
        DRAIN: begin
          // A/B reg, M reg and P reg sit between the feeder and dsp_p
          if (drain_q == '0) begin
            state_q     <= DONE;
            out_data_q  <= bus.dsp_p;
            out_valid_q <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.dsp_a      = dsp_a_q;
  assign bus.dsp_b      = dsp_b_q;
  assign bus.dsp_rstp   = dsp_rstp_q;
  assign bus.dsp_opmode = 8'h09;
endmodule

// File: tb/tb_mac_feeder.sv
// tb/tb_mac_feeder.sv - directed bench for mac_feeder with a behavioural DSP-slice model
module tb_mac_feeder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mac_feeder_if #(.LEN_W(8)) bus();

  mac_feeder #(.LEN_W(8), .LAT(4)) u_dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  // DSP slice: A1/B1 regs, M reg, P reg with synchronous RSTP
  logic signed [17:0] a1_m = '0;
  logic signed [17:0] b1_m = '0;
  logic signed [35:0] m_m  = '0;
  logic signed [47:0] p_m  = '0;
  always @(posedge clk) begin
    a1_m <= bus.dsp_a;
    b1_m <= bus.dsp_b;
    m_m  <= a1_m * b1_m;
    p_m  <= bus.dsp_rstp ? 48'sd0 : p_m + {{12{m_m[35]}}, m_m};
  end
  assign bus.dsp_p = p_m;

  int errors = 0;
  int checks = 0;
  logic signed [17:0] va[$];
  logic signed [17:0] vb[$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic feed(input int n, input int gap, output int timeouts);
    int w;
    timeouts = 0;
    for (int i = 0; i < n; i++) begin
      repeat (gap) tick();
      bus.in_valid = 1'b1;
      bus.in_a     = va[i];
      bus.in_b     = vb[i];
      w = 0;
      while (!bus.in_ready && w < 20) begin
        tick();
        w++;
      end
      if (w >= 20) timeouts++;
      tick();
      bus.in_valid = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_out;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 48'd0) begin errors++; $display("FAIL rst_out_data: got %0d expected 0", bus.out_data); end
    checks++; if (bus.dsp_a !== 18'd0 || bus.dsp_b !== 18'd0) begin errors++; $display("FAIL rst_dsp_ab: got %0d/%0d expected 0/0", bus.dsp_a, bus.dsp_b); end
    checks++; if (bus.dsp_rstp !== 1'b1) begin errors++; $display("FAIL rst_rstp: got %b expected 1", bus.dsp_rstp); end
    checks++; if (bus.dsp_opmode !== 8'h09) begin errors++; $display("FAIL rst_opmode: got %h expected 09", bus.dsp_opmode); end
    rst_n     = 1'b1;
    bus.start = 1'b1;
    bus.len   = 8'd0;
    tick();
    checks++; if (bus.dsp_rstp !== 1'b0) begin errors++; $display("FAIL rel_rstp_drop: got %b expected 0", bus.dsp_rstp); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rel_first_edge_start: busy got %b expected 0", bus.busy); end
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL rel_second_edge_start: busy/valid got %b/%b expected 1/1", bus.busy, bus.out_valid); end
    release_out();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rel_idle: busy got %b expected 0", bus.busy); end
  endtask

  task automatic run_vector(input string name, input int gap);
    int to;
    int lat;
    pulse_start(8'd3);
    checks++; if (bus.in_ready !== 1'b1 || bus.dsp_rstp !== 1'b1) begin errors++; $display("FAIL %s_start: ready/rstp got %b/%b expected 1/1", name, bus.in_ready, bus.dsp_rstp); end
    feed(3, gap, to);
    checks++; if (to !== 0) begin errors++; $display("FAIL %s_accept_timeout: got %0d expected 0", name, to); end
    checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL %s_drain: ready/busy got %b/%b expected 0/1", name, bus.in_ready, bus.busy); end
    wait_valid(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL %s_latency: got %0d expected 4", name, lat); end
    checks++; if (bus.out_data !== 48'd35) begin errors++; $display("FAIL %s_result: got %0d expected 35", name, bus.out_data); end
    release_out();
    checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL %s_release: valid/busy got %b/%b expected 0/0", name, bus.out_valid, bus.busy); end
  endtask

  task automatic test_back_to_back;
    va = {18'sd2, -18'sd4, 18'sd7};
    vb = {18'sd3, 18'sd5, 18'sd7};
    run_vector("b2b", 0);
  endtask

  task automatic test_gaps;
    va = {18'sd2, -18'sd4, 18'sd7};
    vb = {18'sd3, 18'sd5, 18'sd7};
    run_vector("gaps", 2);
  endtask

  task automatic test_len_zero;
    pulse_start(8'd0);
    checks++; if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL len0_done: valid/busy got %b/%b expected 1/1", bus.out_valid, bus.busy); end
    checks++; if (bus.out_data !== 48'd0) begin errors++; $display("FAIL len0_data: got %0d expected 0", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b0 || bus.dsp_rstp !== 1'b1) begin errors++; $display("FAIL len0_ready_rstp: got %b/%b expected 0/1", bus.in_ready, bus.dsp_rstp); end
    tick();
    checks++; if (bus.in_ready !== 1'b0 || bus.dsp_rstp !== 1'b0) begin errors++; $display("FAIL len0_after: ready/rstp got %b/%b expected 0/0", bus.in_ready, bus.dsp_rstp); end
    release_out();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL len0_idle: busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_hold;
    int to;
    int lat;
    va = {18'sd5};
    vb = {18'sd6};
    pulse_start(8'd1);
    feed(1, 0, to);
    wait_valid(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL hold_latency: got %0d expected 4", lat); end
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 3);
      bus.len   = 8'd2;
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 48'd30 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_cycle%0d: valid/data/ready got %b/%0d/%b expected 1/30/0", i, bus.out_valid, bus.out_data, bus.in_ready); end
    end
    bus.start = 1'b0;
    release_out();
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_release: busy/valid got %b/%b expected 0/0", bus.busy, bus.out_valid); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_start_ignored: busy/ready got %b/%b expected 0/0", bus.busy, bus.in_ready); end
  endtask

  task automatic test_long;
    int to;
    int lat;
    va.delete();
    vb.delete();
    for (int i = 0; i < 255; i++) begin
      va.push_back(18'sh20000);
      vb.push_back(18'sh20000);
    end
    pulse_start(8'd255);
    feed(255, 0, to);
    checks++; if (to !== 0) begin errors++; $display("FAIL long_accept_timeout: got %0d expected 0", to); end
    wait_valid(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL long_latency: got %0d expected 4", lat); end
    checks++; if (bus.out_data !== 48'd4380866641920) begin errors++; $display("FAIL long_result: got %0d expected 4380866641920", bus.out_data); end
    release_out();
    va = {18'sd1};
    vb = {-18'sd1};
    pulse_start(8'd1);
    feed(1, 0, to);
    wait_valid(lat);
    checks++; if (bus.out_data !== 48'hFFFF_FFFF_FFFF) begin errors++; $display("FAIL long_clear_p: got %h expected ffffffffffff", bus.out_data); end
    release_out();
  endtask

  task automatic test_reset_mid;
    int to;
    int lat;
    va = {18'sd2, -18'sd4, 18'sd7};
    vb = {18'sd3, 18'sd5, 18'sd7};
    pulse_start(8'd3);
    feed(2, 0, to);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: busy/ready/valid got %b/%b/%b expected 0/0/0", bus.busy, bus.in_ready, bus.out_valid); end
    checks++; if (bus.out_data !== 48'd0 || bus.dsp_a !== 18'd0 || bus.dsp_b !== 18'd0) begin errors++; $display("FAIL rmid_data: data/a/b got %0d/%0d/%0d expected 0/0/0", bus.out_data, bus.dsp_a, bus.dsp_b); end
    checks++; if (bus.dsp_rstp !== 1'b1) begin errors++; $display("FAIL rmid_rstp: got %b expected 1", bus.dsp_rstp); end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    va = {18'sd3};
    vb = {18'sd3};
    pulse_start(8'd1);
    feed(1, 0, to);
    checks++; if (to !== 0) begin errors++; $display("FAIL rmid_accept_timeout: got %0d expected 0", to); end
    wait_valid(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rmid_latency: got %0d expected 4", lat); end
    checks++; if (bus.out_data !== 48'd9) begin errors++; $display("FAIL rmid_result: got %0d expected 9", bus.out_data); end
    release_out();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_len_zero();
    test_gaps();
    test_hold();
    test_long();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mac_feeder.md
MAC_FEEDER -- requirements
Module: mac_feeder

Interface
REQ-001 The module SHALL have parameter LEN_W, default 8, giving the width of the vector-length field.
REQ-002 The module SHALL have parameter LAT, default 4, giving the number of cycles from the edge that accepts the last operand to the edge that captures the result.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to begin a dot product.
REQ-006 len  input  LEN_W  number of operand pairs, sampled with start.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 in_valid  input  1  operand pair present.
REQ-009 in_ready  output  1  feeder accepts an operand pair.
REQ-010 in_a, in_b  input  18 each  signed operands.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 out_data  output  48  signed dot-product result.
REQ-014 dsp_a, dsp_b  output  18 each  operands to the DSP A and B ports.
REQ-015 dsp_opmode  output  8  DSP OPMODE.
REQ-016 dsp_rstp  output  1  DSP P-register reset.
REQ-017 dsp_p  input  48  DSP P output.

Function
REQ-018 The feeder SHALL drive a DSP slice configured with A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1 and B_INPUT="DIRECT"; all DSP clock enables are tied high and all other DSP resets are tied low externally.
REQ-019 dsp_opmode SHALL be the constant 8'h09 at all times: X=M, Z=P, add, pre-adder bypassed, carry 0.
REQ-020 The FSM SHALL have four states, IDLE, RUN, DRAIN and DONE, with the transitions below.
REQ-021 IDLE -> RUN on start=1 when len!=0; IDLE -> DONE on start=1 when len==0, with out_data=0.
REQ-022 start SHALL be ignored in every state other than IDLE.
REQ-023 On the edge that accepts start, remaining count SHALL load len, and dsp_rstp SHALL be registered high for exactly one cycle to clear P.
REQ-024 in_ready SHALL equal (state==RUN).
REQ-025 An operand pair SHALL be accepted on an edge where in_valid and in_ready are both high.
REQ-026 On an accepting edge, dsp_a and dsp_b SHALL be registered from in_a and in_b, and the remaining count SHALL decrement.
REQ-027 On every non-accepting edge, dsp_a and dsp_b SHALL be registered to 0, so a bubble adds a zero product.
REQ-028 RUN -> DRAIN on the edge that accepts the pair bringing the remaining count to 0.
REQ-029 DRAIN SHALL last LAT cycles, counted by a drain counter.
REQ-030 On the LAT-th edge after the last accept, dsp_p SHALL be captured into out_data, out_valid SHALL go high, and the state SHALL move to DONE.
REQ-031 In DONE, out_valid and out_data SHALL hold until out_ready=1; on that edge out_valid drops and the state returns to IDLE.
REQ-032 Arithmetic SHALL be signed 18x18 products accumulated modulo 2^48; no saturation and no overflow flag.
REQ-033 in_valid gaps mid-vector SHALL NOT change the result.
REQ-034 out_valid SHALL rise no earlier and no later than LAT cycles after the last accept.

Reset
REQ-035 While RST_N=0, the state SHALL be IDLE, and busy, in_ready, out_valid, out_data, dsp_a and dsp_b SHALL be 0.
REQ-036 While RST_N=0, dsp_rstp SHALL be 1, and dsp_opmode SHALL be 8'h09.
REQ-037 Asserting reset mid-RUN or mid-DRAIN SHALL abandon the vector immediately.
REQ-038 After RST_N deasserts, dsp_rstp SHALL drop on the first edge, and start SHALL be honoured from the second edge.

Verification
REQ-039 start, len=3; pairs (2,3), (-4,5), (7,7) back-to-back -> out_data=35, out_valid high 4 cycles after the third accept.
REQ-040 start, len=0 -> DONE one edge later with out_data=0, no in_ready pulse, and dsp_rstp pulsed.
REQ-041 len=3, same pairs as REQ-039 with 2-cycle in_valid gaps -> out_data=35, out_valid 4 cycles after the last accept.
REQ-042 out_ready held low for 10 cycles in DONE; start pulsed meanwhile -> out_data stable, start ignored, IDLE only after out_ready.
REQ-043 len=255, all pairs (-131072,-131072) -> out_data=4380866641920; then a second vector of len=1 with pair (1,-1) -> out_data=-1, proving P was cleared.
REQ-044 RST_N pulsed low after 2 accepts of a len=3 vector -> all outputs 0 at once; a new len=1 vector with pair (3,3) -> out_data=9.
